// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, master state encoding and
// the register map used by axi_lite_master and its peer axi_lite_control.
package axi_lite_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_REQ  = 3'd1;
  localparam logic [2:0] ST_WR_RESP = 3'd2;
  localparam logic [2:0] ST_RD_REQ  = 3'd3;
  localparam logic [2:0] ST_RD_RESP = 3'd4;
  localparam logic [2:0] ST_RSP     = 3'd5;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    WR_REQ  = ST_WR_REQ,
    WR_RESP = ST_WR_RESP,
    RD_REQ  = ST_RD_REQ,
    RD_RESP = ST_RD_RESP,
    RSP     = ST_RSP
  } state_t;

  localparam logic [7:0] ADDR_CTRL       = 8'h00;
  localparam logic [7:0] ADDR_STATUS     = 8'h04;
  localparam logic [7:0] ADDR_CONFIG     = 8'h08;
  localparam logic [7:0] ADDR_IRQ_EN     = 8'h0C;
  localparam logic [7:0] ADDR_VERSION    = 8'h10;
  localparam logic [7:0] ADDR_CORE_CFG   = 8'h14;
  localparam logic [7:0] ADDR_PPU_CFG    = 8'h18;
  localparam logic [7:0] ADDR_PPU_GAIN   = 8'h1C;
  localparam logic [7:0] ADDR_PPU_OFFSET = 8'h20;
  localparam logic [7:0] ADDR_OUTPUT_EN  = 8'h24;

  // True while an AXI transaction is in flight and the slave owes us a handshake.
  function automatic logic waiting_on_slave(state_t s);
    return (s == WR_REQ) || (s == WR_RESP) || (s == RD_REQ) || (s == RD_RESP);
  endfunction

endpackage

// File: rtl/axi_lite_watchdog.sv
// Saturating cycle counter with synchronous clear and a sticky expiry flag.
// C_TIMEOUT = 0 disables expiry entirely.
module axi_lite_watchdog #(
  parameter int C_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (C_TIMEOUT > 1) ? $clog2(C_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(C_TIMEOUT);

  logic [CW-1:0] cnt_q;

  // Count enabled cycles up to LIMIT and hold there; flag once LIMIT is reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      expired <= 1'b0;
    end else if (clear) begin
      cnt_q   <= '0;
      expired <= 1'b0;
    end else if (enable && (C_TIMEOUT != 0) && (cnt_q != LIMIT)) begin
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q + 1'b1 == LIMIT) expired <= 1'b1;
    end
  end

endmodule

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator: one register command in, one AXI
// write (AW+W, B) or read (AR, R) out, one response back. A watchdog marks
// responses from slow or hung slaves; transactions are never aborted since
// AXI does not allow a valid to be withdrawn.
//
// state   | meaning
// IDLE    | ready for a command
// WR_REQ  | AW and W presented, each retired on its own handshake
// WR_RESP | bready high, waiting for B
// RD_REQ  | AR presented
// RD_RESP | rready high, waiting for R
// RSP     | response held on rsp_* until rsp_ready
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 6,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_TIMEOUT          = 1024
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            rsp_timeout,
  output logic                            o_busy,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic                            m_axi_awvalid,
  input  logic                            m_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                            m_axi_wvalid,
  input  logic                            m_axi_wready,
  input  logic [1:0]                      m_axi_bresp,
  input  logic                            m_axi_bvalid,
  output logic                            m_axi_bready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic                            m_axi_arvalid,
  input  logic                            m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                      m_axi_rresp,
  input  logic                            m_axi_rvalid,
  output logic                            m_axi_rready
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int SW = C_M_AXI_DATA_WIDTH / 8;

  state_t          state_q, state_d;
  logic [AW-1:0]   awaddr_d, araddr_d;
  logic [DW-1:0]   wdata_d, rsp_rdata_d;
  logic [SW-1:0]   wstrb_d;
  logic            awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
  logic            rsp_valid_d;
  logic [1:0]      rsp_resp_d;
  logic            wd_clear, wd_expired;

  assign cmd_ready   = (state_q == IDLE);
  assign o_busy      = (state_q != IDLE);
  // The sticky flag is frozen while in RSP, so it is stable alongside rsp_*.
  assign rsp_timeout = (state_q == RSP) && wd_expired;

  axi_lite_watchdog #(
    .C_TIMEOUT (C_TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (wd_clear),
    .enable  (waiting_on_slave(state_q)),
    .expired (wd_expired)
  );

  // Next-state and next-output decode; every AXI and rsp output is registered.
  always_comb begin
    state_d     = state_q;
    awaddr_d    = m_axi_awaddr;
    araddr_d    = m_axi_araddr;
    wdata_d     = m_axi_wdata;
    wstrb_d     = m_axi_wstrb;
    awvalid_d   = m_axi_awvalid;
    wvalid_d    = m_axi_wvalid;
    bready_d    = m_axi_bready;
    arvalid_d   = m_axi_arvalid;
    rready_d    = m_axi_rready;
    rsp_valid_d = rsp_valid;
    rsp_rdata_d = rsp_rdata;
    rsp_resp_d  = rsp_resp;
    wd_clear    = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          wd_clear = 1'b1;
          if (cmd_write) begin
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_REQ;
          end else begin
            araddr_d  = cmd_addr;
            arvalid_d = 1'b1;
            state_d   = RD_REQ;
          end
        end
      end
      WR_REQ: begin
        // A low valid here means that channel already handshook.
        if (m_axi_awvalid && m_axi_awready) awvalid_d = 1'b0;
        if (m_axi_wvalid && m_axi_wready)   wvalid_d  = 1'b0;
        if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (m_axi_bvalid) begin
          rsp_resp_d  = m_axi_bresp;
          rsp_rdata_d = '0;
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end
      RD_REQ: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_RESP;
        end
      end
      RD_RESP: begin
        if (m_axi_rvalid) begin
          rsp_rdata_d = m_axi_rdata;
          rsp_resp_d  = m_axi_rresp;
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops every valid/ready at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      m_axi_awaddr  <= '0;
      m_axi_araddr  <= '0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= OKAY;
    end else begin
      state_q       <= state_d;
      m_axi_awaddr  <= awaddr_d;
      m_axi_araddr  <= araddr_d;
      m_axi_wdata   <= wdata_d;
      m_axi_wstrb   <= wstrb_d;
      m_axi_awvalid <= awvalid_d;
      m_axi_wvalid  <= wvalid_d;
      m_axi_bready  <= bready_d;
      m_axi_arvalid <= arvalid_d;
      m_axi_rready  <= rready_d;
      rsp_valid     <= rsp_valid_d;
      rsp_rdata     <= rsp_rdata_d;
      rsp_resp      <= rsp_resp_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: a delay-programmable register slave, a protocol
// monitor, and a reference register map that predicts data, response code,
// latency and watchdog outcome for directed and random commands.
module tb_axi_lite_master;

  localparam int TMO = 16;
  localparam logic [31:0] VERSION = 32'h2026_0117;

  logic        clk, rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [5:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_timeout, o_busy;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [5:0]  awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  axi_lite_master #(
    .C_M_AXI_ADDR_WIDTH (6),
    .C_M_AXI_DATA_WIDTH (32),
    .C_TIMEOUT          (TMO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .cmd_wstrb     (cmd_wstrb),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rdata     (rsp_rdata),
    .rsp_resp      (rsp_resp),
    .rsp_timeout   (rsp_timeout),
    .o_busy        (o_busy),
    .m_axi_awaddr  (awaddr),
    .m_axi_awvalid (awvalid),
    .m_axi_awready (awready),
    .m_axi_wdata   (wdata),
    .m_axi_wstrb   (wstrb),
    .m_axi_wvalid  (wvalid),
    .m_axi_wready  (wready),
    .m_axi_bresp   (bresp),
    .m_axi_bvalid  (bvalid),
    .m_axi_bready  (bready),
    .m_axi_araddr  (araddr),
    .m_axi_arvalid (arvalid),
    .m_axi_arready (arready),
    .m_axi_rdata   (rdata),
    .m_axi_rresp   (rresp),
    .m_axi_rvalid  (rvalid),
    .m_axi_rready  (rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- slave model ----------------
  int dly_aw, dly_w, dly_b, dly_ar, dly_r;
  logic [1:0] cfg_bresp, cfg_rresp;
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, b_hs_cnt;
  logic aw_done, w_done, b_pending, r_pending;
  logic [5:0]  aw_addr_q;
  logic [31:0] w_data_q, r_data_q;
  logic [3:0]  w_strb_q;
  logic [31:0] mem [16] = '{default: 32'h0};

  wire aw_hs   = awvalid && awready;
  wire w_hs    = wvalid && wready;
  wire aw_have = aw_done || aw_hs;
  wire w_have  = w_done || w_hs;
  wire [5:0]  wr_addr = aw_done ? aw_addr_q : awaddr;
  wire [31:0] wr_data = w_done ? w_data_q : wdata;
  wire [3:0]  wr_strb = w_done ? w_strb_q : wstrb;

  assign awready = awvalid && !aw_done && (aw_cnt >= dly_aw);
  assign wready  = wvalid && !w_done && (w_cnt >= dly_w);
  assign bvalid  = b_pending && (b_cnt >= dly_b);
  assign bresp   = cfg_bresp;
  assign arready = arvalid && !r_pending && (ar_cnt >= dly_ar);
  assign rvalid  = r_pending && (r_cnt >= dly_r);
  assign rdata   = r_data_q;
  assign rresp   = cfg_rresp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      aw_done <= 1'b0; w_done <= 1'b0; b_pending <= 1'b0; r_pending <= 1'b0;
      aw_addr_q <= '0; w_data_q <= '0; w_strb_q <= '0; r_data_q <= '0;
    end else begin
      if (aw_hs) begin
        aw_done <= 1'b1; aw_addr_q <= awaddr; aw_cnt <= 0;
      end else if (awvalid && !aw_done) aw_cnt <= aw_cnt + 1;
      if (w_hs) begin
        w_done <= 1'b1; w_data_q <= wdata; w_strb_q <= wstrb; w_cnt <= 0;
      end else if (wvalid && !w_done) w_cnt <= w_cnt + 1;
      if (aw_have && w_have && !b_pending) begin
        if (wr_addr[5:2] != 4'd4)
          for (int b = 0; b < 4; b++)
            if (wr_strb[b]) mem[wr_addr[5:2]][8*b +: 8] <= wr_data[8*b +: 8];
        b_pending <= 1'b1; b_cnt <= 0; aw_done <= 1'b0; w_done <= 1'b0;
      end else if (b_pending) begin
        if (bvalid && bready) begin
          b_pending <= 1'b0; b_hs_cnt <= b_hs_cnt + 1;
        end else b_cnt <= b_cnt + 1;
      end
      if (arvalid && arready) begin
        r_pending <= 1'b1; r_cnt <= 0; ar_cnt <= 0;
        r_data_q  <= (araddr[5:2] == 4'd4) ? VERSION : mem[araddr[5:2]];
      end else begin
        if (arvalid) ar_cnt <= ar_cnt + 1;
        if (r_pending) begin
          if (rvalid && rready) r_pending <= 1'b0;
          else r_cnt <= r_cnt + 1;
        end
      end
    end
  end

  // ---------------- protocol monitor ----------------
  int viol;
  logic p_aw, p_awr, p_w, p_wr, p_ar, p_arr;
  initial begin viol = 0; b_hs_cnt = 0; end

  always @(negedge clk) begin
    if (rst_n) begin
      if (p_aw && !p_awr && !awvalid) viol <= viol + 1;
      if (p_w && !p_wr && !wvalid)    viol <= viol + 1;
      if (p_ar && !p_arr && !arvalid) viol <= viol + 1;
      if (bready && (awvalid || wvalid || arvalid || rready)) viol <= viol + 1;
      if (rready && (arvalid || awvalid || wvalid)) viol <= viol + 1;
      p_aw <= awvalid; p_awr <= awready; p_w <= wvalid; p_wr <= wready;
      p_ar <= arvalid; p_arr <= arready;
    end else begin
      p_aw <= 1'b0; p_awr <= 1'b0; p_w <= 1'b0; p_wr <= 1'b0;
      p_ar <= 1'b0; p_arr <= 1'b0;
    end
  end

  // ---------------- checking ----------------
  int n_assert, n_fail;
  logic [31:0] ref_mem [16];
  bit last_skew;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one command at a negedge with the DUT idle and check the result
  // against the reference map and the latency implied by the slave delays.
  task automatic run_txn(input bit wr, input logic [5:0] addr, input logic [31:0] wd,
                         input logic [3:0] st, input int hold, input string tag);
    int lat, exp_lat, b0, gap;
    logic [31:0] exp_rd;
    logic [1:0]  exp_rsp;
    logic        exp_to;
    bit          skew;
    int          idx;
    idx     = int'(addr[5:2]);
    exp_lat = wr ? 3 + ((dly_aw > dly_w) ? dly_aw : dly_w) + dly_b : 3 + dly_ar + dly_r;
    exp_to  = (exp_lat - 1) >= TMO;
    if (wr) begin
      exp_rd  = 32'h0;
      exp_rsp = cfg_bresp;
      if (idx != 4)
        for (int b = 0; b < 4; b++) if (st[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
    end else begin
      exp_rd  = (idx == 4) ? VERSION : ref_mem[idx];
      exp_rsp = cfg_rresp;
    end
    b0 = b_hs_cnt;
    chk({tag, " cmd_ready idle"}, cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = st;
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1; skew = 0; gap = 0;
    while (!rsp_valid && lat < 60) begin
      if (!awvalid && wvalid) skew = 1;
      if (wr && !awvalid && !wvalid && !bready) gap++;
      if (!wr && !arvalid && !rready) gap++;
      @(negedge clk);
      lat++;
    end
    chk({tag, " rsp_valid"}, rsp_valid, 1);
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " rdata"}, rsp_rdata, exp_rd);
    chk({tag, " resp"}, rsp_resp, exp_rsp);
    chk({tag, " timeout"}, rsp_timeout, exp_to);
    chk({tag, " ready gap"}, gap, 0);
    chk({tag, " b handshakes"}, b_hs_cnt - b0, wr ? 1 : 0);
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'b1; cmd_write = $urandom_range(0, 1); cmd_addr = 6'h0C;
      @(negedge clk);
      chk({tag, " hold rsp_valid"}, rsp_valid, 1);
      chk({tag, " hold rdata"}, rsp_rdata, exp_rd);
      chk({tag, " hold resp"}, rsp_resp, exp_rsp);
      chk({tag, " hold cmd_ready"}, cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    chk({tag, " rsp dropped"}, rsp_valid, 0);
    chk({tag, " cmd_ready back"}, cmd_ready, 1);
    chk({tag, " not busy"}, o_busy, 0);
    last_skew = skew;
  endtask

  initial begin
    n_assert = 0; n_fail = 0;
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
    dly_aw = 0; dly_w = 0; dly_b = 0; dly_ar = 0; dly_r = 0;
    cfg_bresp = 2'b00; cfg_rresp = 2'b00;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst cmd_ready", cmd_ready, 1);
    chk("rst busy", o_busy, 0);
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst rsp_rdata", rsp_rdata, 0);
    chk("rst rsp_resp", rsp_resp, 0);
    chk("rst rsp_timeout", rsp_timeout, 0);
    chk("rst valids", {awvalid, wvalid, arvalid}, 0);
    chk("rst readies", {bready, rready}, 0);
    chk("rst addr/data", {awaddr, araddr, wdata, wstrb}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(1, 6'h08, 32'h0000_0100, 4'hF, 0, "wr08");
    run_txn(0, 6'h08, 32'h0, 4'h0, 0, "rd08");
    dly_ar = 1;
    run_txn(0, 6'h10, 32'h0, 4'h0, 0, "rd_version");
    dly_ar = 0;

    dly_w = 3;
    run_txn(1, 6'h14, 32'hA5A5_1234, 4'hF, 0, "skew");
    chk("skew aw before w", last_skew, 1);
    dly_w = 0;

    run_txn(0, 6'h14, 32'h0, 4'h0, 5, "backpressure");

    dly_b = 20; cfg_bresp = 2'b10;
    run_txn(1, 6'h18, 32'hDEAD_BEEF, 4'h3, 0, "timeout");
    dly_b = 0; cfg_bresp = 2'b00;
    run_txn(1, 6'h18, 32'h1111_2222, 4'hC, 0, "after_timeout");

    for (int n = 0; n < 30; n++) begin
      dly_aw = $urandom_range(0, 3); dly_w = $urandom_range(0, 3);
      dly_b  = $urandom_range(0, 3); dly_ar = $urandom_range(0, 3);
      dly_r  = $urandom_range(0, 3);
      cfg_bresp = 2'($urandom_range(0, 3)); cfg_rresp = 2'($urandom_range(0, 3));
      run_txn(bit'($urandom_range(0, 1)), 6'(4 * $urandom_range(0, 9)), $urandom,
              4'($urandom_range(0, 15)), $urandom_range(0, 2), "random");
    end
    dly_aw = 0; dly_w = 0; dly_b = 0; dly_r = 0;
    cfg_bresp = 2'b00; cfg_rresp = 2'b00;

    dly_ar = 10;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 6'h08;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("midrst arvalid before", arvalid, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst arvalid", arvalid, 0);
    chk("midrst rready", rready, 0);
    chk("midrst busy", o_busy, 0);
    chk("midrst rsp_valid", rsp_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dly_ar = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("postrst no rsp", rsp_valid, 0);
    end
    chk("postrst cmd_ready", cmd_ready, 1);
    run_txn(0, 6'h18, 32'h0, 4'h0, 0, "postrst_rd");

    chk("protocol violations", viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_lite_master.md
Name: axi_lite_master

Overview:
- Single-outstanding AXI4-Lite initiator. It turns one register command at a time into an AXI4-Lite write (AW+W then B) or read (AR then R), and returns the response on a response channel.
- It is the initiator-side peer of axi_lite_control. It is used by the on-chip boot/config sequencer and by block-level benches to program the core and PPU registers.
- Includes a watchdog that flags slaves that are slow or hung.

Parameters:
- C_M_AXI_ADDR_WIDTH, 6, AXI address width; must match the peer slave.
- C_M_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- C_TIMEOUT, 1024, cycles from command accept before rsp_timeout is flagged; 0 disables the watchdog.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  32  write data.
- cmd_wstrb  in  4  write strobes.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP captured from the slave.
- rsp_timeout  out  1  watchdog expired during this transaction.
- o_busy  out  1  high whenever state != IDLE.
- m_axi_awaddr  out  ADDR_WIDTH  write address.
- m_axi_awvalid  out  1  write address valid.
- m_axi_awready  in  1  write address ready.
- m_axi_wdata  out  32  write data.
- m_axi_wstrb  out  4  write strobes.
- m_axi_wvalid  out  1  write data valid.
- m_axi_wready  in  1  write data ready.
- m_axi_bresp  in  2  write response.
- m_axi_bvalid  in  1  write response valid.
- m_axi_bready  out  1  write response ready.
- m_axi_araddr  out  ADDR_WIDTH  read address.
- m_axi_arvalid  out  1  read address valid.
- m_axi_arready  in  1  read address ready.
- m_axi_rdata  in  32  read data.
- m_axi_rresp  in  2  read response.
- m_axi_rvalid  in  1  read data valid.
- m_axi_rready  out  1  read data ready.

Behaviour:
- Reset values:
  - state = IDLE.
  - All m_axi valid/ready outputs 0; all address/data/strobe outputs 0.
  - rsp_valid, rsp_rdata, rsp_resp, rsp_timeout all 0; o_busy 0.
  - cmd_ready = (state == IDLE), a combinational decode of state.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE:
  - On cmd_valid, latch addr/wdata/wstrb/write into the AXI output registers and clear the watchdog.
  - Write: awvalid = 1 and wvalid = 1 next cycle; go to WR_REQ.
  - Read: arvalid = 1 next cycle; go to RD_REQ.
- WR_REQ:
  - awvalid and wvalid are tracked independently; each deasserts on the cycle after its own valid&&ready.
  - Neither valid may drop before its handshake.
  - Both handshaking in the same cycle is legal.
  - Once both are done, go to WR_RESP with bready = 1.
- WR_RESP:
  - On bvalid&&bready: capture bresp; rsp_rdata = 0; bready = 0; go to RSP.
- RD_REQ:
  - arvalid holds until arready; then arvalid = 0, rready = 1; go to RD_RESP.
- RD_RESP:
  - On rvalid&&rready: capture rdata and rresp; rready = 0; go to RSP.
- RSP:
  - rsp_valid = 1; rsp_* fields are stable until rsp_ready.
  - On handshake: rsp_valid = 0; go to IDLE. cmd_ready reasserts that cycle, so back-to-back commands have one idle gap.
- Ready signals are never asserted before entering their wait state (bready only in WR_RESP, rready only in RD_RESP).
- Latency with a zero-wait slave (readies and valids combinationally high):
  - Command accepted at edge 0; AXI request valid in cycle 1.
  - Response handshake in cycle 2.
  - rsp_valid in cycle 3.
  - axi_lite_control adds 1 cycle on the request side; rsp_valid arrives in cycle 4 for writes and reads.
- Watchdog:
  - The counter runs whenever state is WR_REQ, WR_RESP, RD_REQ or RD_RESP, and saturates.
  - Reaching C_TIMEOUT sets a sticky timeout bit, presented as rsp_timeout with the eventual response.
  - The transaction is never aborted, because AXI forbids withdrawing valid.
  - The counter and the sticky bit clear on command accept.
- rsp_resp passes the slave's value unmodified; SLVERR/DECERR do not change the flow.
- Reset mid-transaction asynchronously returns to IDLE, drops all valids/readies, and discards the in-flight command with no response. The system must reset the peer slave in the same domain.
- cmd_* inputs are ignored outside IDLE.

Decomposition:
- Shared package axi_lite_pkg holds:
  - Response codes OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11.
  - The state encoding localparams.
  - The register address constants (CTRL 0x00 through OUTPUT_EN 0x24) shared with axi_lite_control.
- One natural sub-module: axi_lite_watchdog, a saturating counter with clear, enable and sticky expiry flag.

Test Plan:
- Write against axi_lite_control: addr 0x08, data 0x00000100, strb 0xF.
  - rsp_resp = 0 and rsp_timeout = 0.
  - A following read of 0x08 returns rsp_rdata = 0x00000100.
- Read 0x10: rsp_rdata = 0x20260117, rsp_resp = 0, rsp_valid 4 cycles after accept.
- Skewed slave: awready 3 cycles before wready.
  - awvalid drops after its handshake while wvalid holds.
  - Exactly one B handshake; rsp_valid once.
- Backpressure: rsp_ready low for 5 cycles.
  - rsp_valid, rsp_rdata and rsp_resp are held stable.
  - cmd_ready = 0 and a second command is not accepted until the rsp handshake.
- Timeout with C_TIMEOUT = 16: bvalid delayed 20 cycles with bresp = 2'b10.
  - bready stays high throughout.
  - Response arrives with rsp_resp = 2'b10 and rsp_timeout = 1.
  - The next write completes with rsp_timeout = 0.
- Reset mid-read: assert rst_n low while arvalid = 1.
  - arvalid and rready = 0 immediately; state IDLE; no rsp_valid.
  - After release, cmd_ready = 1.
